// File: rtl/muldiv_controller.sv
// Multi-cycle signed multiply/divide sequencer with pipeline front-end stall.
// Operands are reduced to magnitudes, iterated unsigned for WIDTH cycles,
// then sign-corrected in FIX.
module muldiv_controller #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             pc_write,
  output logic             ifid_write
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] opnd_q,   opnd_d;
  logic [WIDTH-1:0] orig_a_q, orig_a_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             op_q,     op_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic             dbz_q,    dbz_d;

  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [ACC_W-1:0] mul_step_c;
  logic [WIDTH-1:0] rem_sh_c;
  logic [WIDTH:0]   diff_c;
  logic [ACC_W-1:0] div_step_c;
  logic [ACC_W-1:0] prod_c;
  logic [WIDTH-1:0] quot_c, rem_c;
  logic             stall_c;

  // Operand magnitudes, one iteration of each algorithm, and sign fix-up.
  always_comb begin
    mag_a_c    = operand_a[WIDTH-1] ? -operand_a : operand_a;
    mag_b_c    = operand_b[WIDTH-1] ? -operand_b : operand_b;
    // Shift-add: upper half accumulates, multiplier bits retire from the LSB.
    mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    // Restoring divide: remainder stays below the divisor, so its MSB is always 0.
    rem_sh_c   = {acc_q[ACC_W-2:WIDTH], acc_q[WIDTH-1]};
    diff_c     = {1'b0, rem_sh_c} - {1'b0, opnd_q};
    div_step_c = diff_c[WIDTH] ? {rem_sh_c, acc_q[WIDTH-2:0], 1'b0}
                               : {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_c     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_c     = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_c      = sign_a_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
  end

  // Next-state and register updates for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    orig_a_d = orig_a_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          sign_a_d = operand_a[WIDTH-1];
          sign_b_d = operand_b[WIDTH-1];
          orig_a_d = operand_a;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          opnd_d   = op ? mag_b_c : mag_a_c;
          acc_d    = {WIDTH'(0), (op ? mag_a_c : mag_b_c)};
          if (op && (operand_b == '0)) begin
            state_d = FIX;
            busy_d  = 1'b0;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        acc_d = op_q ? div_step_c : mul_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
          busy_d  = 1'b0;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (op_q && (opnd_q == '0)) begin
          lo_d  = '1;
          hi_d  = orig_a_q;
          dbz_d = 1'b1;
        end else if (op_q) begin
          lo_d = quot_c;
          hi_d = rem_c;
        end else begin
          lo_d = prod_c[WIDTH-1:0];
          hi_d = prod_c[ACC_W-1:WIDTH];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      orig_a_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      orig_a_q <= orig_a_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
    end
  end

  // Freeze PC and IF/ID from the accepting cycle until the last iteration.
  always_comb begin
    stall_c = busy_q | (start & (state_q == IDLE));
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign div_by_zero = dbz_q;
  assign pc_write    = ~stall_c;
  assign ifid_write  = ~stall_c;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed and randomized checks of muldiv_controller against an arithmetic model.
module tb_muldiv_controller;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, div_by_zero, pc_write, ifid_write;
  logic [W-1:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Signed arithmetic reference: returns {div_by_zero, hi, lo}.
  function automatic logic [32:0] model(input logic o, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, p, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!o) begin
      p = sa * sb;
      return {1'b0, 32'(p)};
    end
    if (b == 16'h0000) return {1'b1, a, 16'hFFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, 16'(r), 16'(q)};
  endfunction

  task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
  endtask

  // Presents a request now and follows it to the done cycle (ends at that cycle's negedge).
  task automatic run(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b,
                     input logic [32:0] exp, input int inject_at);
    int  lat, stall, exp_lat;
    bit  seen;
    exp_lat = (o && b == 16'h0000) ? 1 : 17;
    issue(o, a, b);
    #1;
    chk({tag, ":pc_e0"}, 32'(pc_write), 32'd0);
    chk({tag, ":ifid_e0"}, 32'(ifid_write), 32'd0);
    stall = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, ":dbz_clr"}, 32'(div_by_zero), 32'd0);
      if (done) seen = 1'b1;
      else if (!pc_write) stall++;
      if (lat == inject_at) issue(~o, a ^ 16'h5A5A, b + 16'h0001);
      else if (lat == inject_at + 1) start = 1'b0;
    end
    chk({tag, ":latency"}, 32'(lat - 1), 32'(exp_lat));
    chk({tag, ":stall"}, 32'(stall), 32'(exp_lat));
    if (seen) begin
      chk({tag, ":lo"}, 32'(result_lo), 32'(exp[15:0]));
      chk({tag, ":hi"}, 32'(result_hi), 32'(exp[31:16]));
      chk({tag, ":dbz"}, 32'(div_by_zero), 32'(exp[32]));
      chk({tag, ":busy_done"}, 32'(busy), 32'd0);
      chk({tag, ":pc_done"}, 32'(pc_write), 32'd1);
    end
  endtask

  // One cycle after done: pulse gone, results held.
  task automatic post(input string tag, input logic [32:0] exp);
    @(negedge clk);
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    chk({tag, ":lo_hold"}, 32'(result_lo), 32'(exp[15:0]));
    chk({tag, ":hi_hold"}, 32'(result_hi), 32'(exp[31:16]));
  endtask

  initial begin
    logic [32:0] e;
    logic [15:0] ra, rb;
    logic        ro;
    int          ndone;

    // Reset values while held in reset.
    #2;
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:lo", 32'(result_lo), 32'd0);
    chk("rst:hi", 32'(result_hi), 32'd0);
    chk("rst:dbz", 32'(div_by_zero), 32'd0);
    chk("rst:pc", 32'(pc_write), 32'd1);
    chk("rst:ifid", 32'(ifid_write), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    run("mul7x-3", 1'b0, 16'h0007, 16'hFFFD, {1'b0, 16'hFFFF, 16'hFFEB}, 0);
    post("mul7x-3", {1'b0, 16'hFFFF, 16'hFFEB});
    run("mul300", 1'b0, 16'd300, 16'd300, {1'b0, 16'h0001, 16'h5F90}, 0);
    post("mul300", {1'b0, 16'h0001, 16'h5F90});
    run("mulmin", 1'b0, 16'h8000, 16'h8000, {1'b0, 16'h4000, 16'h0000}, 0);
    post("mulmin", {1'b0, 16'h4000, 16'h0000});
    run("div-7/2", 1'b1, 16'hFFF9, 16'h0002, {1'b0, 16'hFFFF, 16'hFFFD}, 0);
    post("div-7/2", {1'b0, 16'hFFFF, 16'hFFFD});
    run("divovf", 1'b1, 16'h8000, 16'hFFFF, {1'b0, 16'h0000, 16'h8000}, 0);
    post("divovf", {1'b0, 16'h0000, 16'h8000});
    run("div0", 1'b1, 16'h1234, 16'h0000, {1'b1, 16'h1234, 16'hFFFF}, 0);
    post("div0", {1'b1, 16'h1234, 16'hFFFF});

    // Start during CALC is ignored.
    run("ignore", 1'b0, 16'h0123, 16'hFF00, model(1'b0, 16'h0123, 16'hFF00), 5);
    post("ignore", model(1'b0, 16'h0123, 16'hFF00));

    // Back-to-back: second request presented in the done cycle.
    run("b2b_1", 1'b1, 16'd1000, 16'hFFF9, model(1'b1, 16'd1000, 16'hFFF9), 0);
    run("b2b_2", 1'b0, 16'hFF38, 16'd77, model(1'b0, 16'hFF38, 16'd77), 0);
    post("b2b_2", model(1'b0, 16'hFF38, 16'd77));

    // Asynchronous reset in the middle of a divide.
    issue(1'b1, 16'h7FFF, 16'h0003);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:done", 32'(done), 32'd0);
    chk("abort:lo", 32'(result_lo), 32'd0);
    chk("abort:hi", 32'(result_hi), 32'd0);
    chk("abort:dbz", 32'(div_by_zero), 32'd0);
    chk("abort:pc", 32'(pc_write), 32'd1);
    chk("abort:ifid", 32'(ifid_write), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort:no_done", 32'(ndone), 32'd0);
    chk("abort:idle_busy", 32'(busy), 32'd0);
    run("after_rst", 1'b1, 16'h7FFF, 16'h0003, model(1'b1, 16'h7FFF, 16'h0003), 0);
    post("after_rst", model(1'b1, 16'h7FFF, 16'h0003));

    // Randomized operations including corner operands.
    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       ra = 16'h8000;
        1:       ra = 16'hFFFF;
        2:       ra = 16'h0000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'h8000;
        2:       rb = 16'hFFFF;
        3:       rb = 16'($urandom_range(1, 9));
        default: rb = 16'($urandom);
      endcase
      e = model(ro, ra, rb);
      run($sformatf("rnd%0d", i), ro, ra, rb, e, 0);
      post($sformatf("rnd%0d", i), e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
